// File: rtl/edge_pkg.sv
// Shared types and helpers for the multi-channel edge detector.
// Optional build macro: EDGE_DEBOUNCE_EN (per-channel stability filter).
package edge_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'd0,
    EDGE_RISE = 2'd1,
    EDGE_FALL = 2'd2,
    EDGE_BOTH = 2'd3
  } edge_mode_t;

  // All-ones value of a w-bit counter (w capped at 64).
  function automatic logic [63:0] cnt_max(input int unsigned w);
    return (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic rise_en(input edge_mode_t m);
    return (m == EDGE_RISE) || (m == EDGE_BOTH);
  endfunction

  function automatic logic fall_en(input edge_mode_t m);
    return (m == EDGE_FALL) || (m == EDGE_BOTH);
  endfunction

endpackage

// File: rtl/edge_channel.sv
// One detector channel: synchroniser, optional debounce (EDGE_DEBOUNCE_EN),
// edge detection, sticky flag and saturating event counter.
module edge_channel
  import edge_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int CNT_W           = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x_i,
  input  edge_mode_t       mode_i,
  input  logic             sticky_clr_i,
  input  logic             cnt_clr_i,
  output logic             edge_o,
  output logic             rise_o,
  output logic             fall_o,
  output logic             level_o,
  output logic             sticky_o,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX_C = CNT_W'(cnt_max(CNT_W));

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
    $error("DEBOUNCE_CYCLES must be >= 1");
  end

  logic xs, xs_vld, smp;

  // A valid bit rides alongside the synchroniser so priming waits until the
  // pipe holds real samples; otherwise an input high through reset would edge.
  if (SYNC_STAGES == 0) begin : g_nosync
    assign xs     = x_i;
    assign xs_vld = 1'b1;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q, vld_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        sync_q <= '0;
        vld_q  <= '0;
      end else begin
        sync_q[0] <= x_i;
        vld_q[0]  <= 1'b1;
        for (int i = 1; i < SYNC_STAGES; i++) begin
          sync_q[i] <= sync_q[i-1];
          vld_q[i]  <= vld_q[i-1];
        end
      end
    end
    assign xs     = sync_q[SYNC_STAGES-1];
    assign xs_vld = vld_q[SYNC_STAGES-1];
  end

  logic primed_q, primed_d, level_q, level_d;

`ifdef EDGE_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  logic            acc_q, acc_d;
  logic [DB_W-1:0] db_q, db_d;

  // Accepted sample moves only after xs disagrees for DEBOUNCE_CYCLES cycles.
  always_comb begin
    acc_d = acc_q;
    db_d  = '0;
    if (!primed_q) begin
      acc_d = xs;
    end else if (xs != acc_q) begin
      if (db_q == DB_W'(DEBOUNCE_CYCLES - 1)) acc_d = xs;
      else                                   db_d  = db_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= 1'b0;
      db_q  <= '0;
    end else begin
      acc_q <= acc_d;
      db_q  <= db_d;
    end
  end

  assign smp = acc_q;
`else
  assign smp = xs;
`endif

  logic             rise_d, fall_d, ev_d, sticky_d;
  logic             rise_q, fall_q, edge_q, sticky_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    rise_d   = primed_q & smp & ~level_q & rise_en(mode_i);
    fall_d   = primed_q & ~smp & level_q & fall_en(mode_i);
    ev_d     = rise_d | fall_d;
    level_d  = primed_q ? smp : xs;
    primed_d = primed_q | xs_vld;
    sticky_d = ev_d | (sticky_q & ~sticky_clr_i);
    if (cnt_clr_i)                      cnt_d = ev_d ? CNT_W'(1) : '0;
    else if (ev_d && cnt_q != CNT_MAX_C) cnt_d = cnt_q + 1'b1;
    else                                 cnt_d = cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      primed_q <= 1'b0;
      level_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      edge_q   <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      primed_q <= primed_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      edge_q   <= ev_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign edge_o   = edge_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
  assign level_o  = level_q;
  assign sticky_o = sticky_q;
  assign cnt_o    = cnt_q;

endmodule

// File: rtl/multi_edge_detector.sv
// N_CH independent edge-detector channels with packed per-channel ports.
// Optional build macro: EDGE_DEBOUNCE_EN (adds a stability filter per channel).
module multi_edge_detector
  import edge_pkg::*;
#(
  parameter int N_CH            = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int CNT_W           = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_CH-1:0]            x,
  input  edge_mode_t [N_CH-1:0]      mode,
  output logic [N_CH-1:0]            edge_o,
  output logic [N_CH-1:0]            rise_o,
  output logic [N_CH-1:0]            fall_o,
  output logic [N_CH-1:0]            level_o,
  output logic [N_CH-1:0]            sticky_o,
  input  logic [N_CH-1:0]            sticky_clr,
  output logic [N_CH-1:0][CNT_W-1:0] cnt_o,
  input  logic [N_CH-1:0]            cnt_clr
);

  if (SYNC_STAGES < 0 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("SYNC_STAGES must be in 0..4");
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    edge_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .CNT_W          (CNT_W),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .x_i         (x[g]),
      .mode_i      (mode[g]),
      .sticky_clr_i(sticky_clr[g]),
      .cnt_clr_i   (cnt_clr[g]),
      .edge_o      (edge_o[g]),
      .rise_o      (rise_o[g]),
      .fall_o      (fall_o[g]),
      .level_o     (level_o[g]),
      .sticky_o    (sticky_o[g]),
      .cnt_o       (cnt_o[g])
    );
  end

endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed-vector bench for multi_edge_detector (N_CH=4, SYNC_STAGES=2, CNT_W=3).
module tb_multi_edge_detector;
  import edge_pkg::*;

  localparam int N_CH = 4;
  localparam int CW   = 3;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [N_CH-1:0]         x;
  edge_mode_t [N_CH-1:0]   mode;
  logic [N_CH-1:0]         edge_o, rise_o, fall_o, level_o, sticky_o;
  logic [N_CH-1:0]         sticky_clr, cnt_clr;
  logic [N_CH-1:0][CW-1:0] cnt_o;

  int checks = 0;
  int errors = 0;

  multi_edge_detector #(
    .N_CH(N_CH), .SYNC_STAGES(2), .CNT_W(CW), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .x(x), .mode(mode),
    .edge_o(edge_o), .rise_o(rise_o), .fall_o(fall_o), .level_o(level_o),
    .sticky_o(sticky_o), .sticky_clr(sticky_clr), .cnt_o(cnt_o), .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_modes(input edge_mode_t m3, input edge_mode_t m2,
                           input edge_mode_t m1, input edge_mode_t m0);
    mode[3] = m3; mode[2] = m2; mode[1] = m1; mode[0] = m0;
  endtask

  task automatic clear_all();
    cnt_clr = '1; sticky_clr = '1;
    tick();
    cnt_clr = '0; sticky_clr = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; x = 4'b0001; cnt_clr = '0; sticky_clr = '0;
    set_modes(EDGE_BOTH, EDGE_BOTH, EDGE_BOTH, EDGE_BOTH);
    tick(3);
    checks++;
    if ({edge_o, rise_o, fall_o, level_o, sticky_o} !== 20'h0 || cnt_o !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got edge=%b rise=%b fall=%b level=%b sticky=%b cnt=%h, want all 0",
               edge_o, rise_o, fall_o, level_o, sticky_o, cnt_o);
    end
    rst = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      checks++;
      if (edge_o !== 4'b0000) begin
        errors++;
        $display("FAIL prime_no_edge cyc%0d: got edge=%b want 0000", i, edge_o);
      end
    end
    checks++;
    if (level_o !== 4'b0001 || cnt_o[0] !== 3'd0) begin
      errors++;
      $display("FAIL prime_level: got level=%b cnt0=%0d want 0001/0", level_o, cnt_o[0]);
    end
  endtask

  task automatic test_rise_fall();
    x[0] = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if (fall_o !== ((i == 3) ? 4'b0001 : 4'b0000) || rise_o !== 4'b0000) begin
        errors++;
        $display("FAIL fall_ch0 cyc%0d: got fall=%b rise=%b want fall=%b rise=0000",
                 i, fall_o, rise_o, (i == 3) ? 4'b0001 : 4'b0000);
      end
    end
    x[0] = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if (rise_o !== ((i == 3) ? 4'b0001 : 4'b0000) || fall_o !== 4'b0000) begin
        errors++;
        $display("FAIL rise_ch0 cyc%0d: got rise=%b fall=%b want rise=%b fall=0000",
                 i, rise_o, fall_o, (i == 3) ? 4'b0001 : 4'b0000);
      end
    end
    checks++;
    if (cnt_o[0] !== 3'd2 || sticky_o !== 4'b0001) begin
      errors++;
      $display("FAIL rise_fall_cnt: got cnt0=%0d sticky=%b want 2/0001", cnt_o[0], sticky_o);
    end
  endtask

  task automatic test_modes();
    x = 4'b0000;
    tick(5);
    clear_all();
    set_modes(EDGE_BOTH, EDGE_FALL, EDGE_RISE, EDGE_OFF);
    x = 4'b1111;
    tick(3);
    checks++;
    if (rise_o !== 4'b1010 || fall_o !== 4'b0000 || edge_o !== 4'b1010) begin
      errors++;
      $display("FAIL modes_rise: got rise=%b fall=%b edge=%b want 1010/0000/1010",
               rise_o, fall_o, edge_o);
    end
    tick(2);
    checks++;
    if (level_o !== 4'b1111) begin
      errors++;
      $display("FAIL modes_level_hi: got %b want 1111", level_o);
    end
    x = 4'b0000;
    tick(3);
    checks++;
    if (fall_o !== 4'b1100 || rise_o !== 4'b0000 || edge_o !== 4'b1100) begin
      errors++;
      $display("FAIL modes_fall: got fall=%b rise=%b edge=%b want 1100/0000/1100",
               fall_o, rise_o, edge_o);
    end
    tick(2);
    checks++;
    if (level_o !== 4'b0000 || cnt_o[0] !== 3'd0 || cnt_o[1] !== 3'd1 ||
        cnt_o[2] !== 3'd1 || cnt_o[3] !== 3'd2 || sticky_o !== 4'b1110) begin
      errors++;
      $display("FAIL modes_counts: got level=%b cnt=%0d,%0d,%0d,%0d sticky=%b want 0000 0,1,1,2 1110",
               level_o, cnt_o[0], cnt_o[1], cnt_o[2], cnt_o[3], sticky_o);
    end
  endtask

  task automatic test_saturation();
    set_modes(EDGE_OFF, EDGE_OFF, EDGE_RISE, EDGE_OFF);
    clear_all();
    for (int e = 1; e <= 9; e++) begin
      x[1] = 1'b1; tick(2);
      x[1] = 1'b0; tick(2);
      if (e == 3) begin
        checks++;
        if (cnt_o[1] !== 3'd3) begin
          errors++;
          $display("FAIL sat_partial: got cnt1=%0d want 3", cnt_o[1]);
        end
      end
    end
    tick(2);
    checks++;
    if (cnt_o[1] !== 3'd7) begin
      errors++;
      $display("FAIL sat_max: got cnt1=%0d want 7", cnt_o[1]);
    end
    // Clear lands on the same edge that registers the rise pulse.
    x[1] = 1'b1;
    tick(2);
    cnt_clr[1] = 1'b1;
    tick();
    cnt_clr[1] = 1'b0;
    checks++;
    if (rise_o[1] !== 1'b1 || cnt_o[1] !== 3'd1) begin
      errors++;
      $display("FAIL clr_with_edge: got rise1=%b cnt1=%0d want 1/1", rise_o[1], cnt_o[1]);
    end
    tick(2);
    cnt_clr[1] = 1'b1;
    tick();
    cnt_clr[1] = 1'b0;
    checks++;
    if (cnt_o[1] !== 3'd0) begin
      errors++;
      $display("FAIL clr_no_edge: got cnt1=%0d want 0", cnt_o[1]);
    end
  endtask

  task automatic test_sticky();
    set_modes(EDGE_OFF, EDGE_BOTH, EDGE_OFF, EDGE_OFF);
    clear_all();
    x[2] = 1'b1;
    tick(3);
    checks++;
    if (sticky_o[2] !== 1'b1) begin
      errors++;
      $display("FAIL sticky_set: got %b want 1", sticky_o[2]);
    end
    tick();
    sticky_clr[2] = 1'b1;
    tick();
    sticky_clr[2] = 1'b0;
    checks++;
    if (sticky_o[2] !== 1'b0) begin
      errors++;
      $display("FAIL sticky_clr: got %b want 0", sticky_o[2]);
    end
    x[2] = 1'b0;
    tick(2);
    sticky_clr[2] = 1'b1;
    tick();
    sticky_clr[2] = 1'b0;
    checks++;
    if (fall_o[2] !== 1'b1 || sticky_o[2] !== 1'b1) begin
      errors++;
      $display("FAIL sticky_set_wins: got fall2=%b sticky2=%b want 1/1", fall_o[2], sticky_o[2]);
    end
  endtask

  task automatic test_back_to_back();
    set_modes(EDGE_BOTH, EDGE_OFF, EDGE_OFF, EDGE_OFF);
    tick(4);
    clear_all();
    for (int i = 0; i < 10; i++) begin
      x[3] = ~x[3];
      tick();
      if (i >= 2) begin
        checks++;
        if (edge_o[3] !== 1'b1 || (rise_o[3] ^ fall_o[3]) !== 1'b1) begin
          errors++;
          $display("FAIL b2b_pulse i%0d: got edge3=%b rise3=%b fall3=%b want continuous pulse",
                   i, edge_o[3], rise_o[3], fall_o[3]);
        end
      end
    end
    checks++;
    if (cnt_o[3] !== 3'd7) begin
      errors++;
      $display("FAIL b2b_sat: got cnt3=%0d want 7", cnt_o[3]);
    end
  endtask

  task automatic test_reset_mid();
    set_modes(EDGE_BOTH, EDGE_OFF, EDGE_OFF, EDGE_OFF);
    tick(4);
    for (int i = 0; i < 14; i++) begin
      x[3] = ~x[3];
      rst  = (i == 6);
      tick();
      if (i == 6) begin
        checks++;
        if ({edge_o, rise_o, fall_o, level_o, sticky_o} !== 20'h0 || cnt_o !== '0) begin
          errors++;
          $display("FAIL midrst_zero: got edge=%b level=%b sticky=%b cnt=%h want all 0",
                   edge_o, level_o, sticky_o, cnt_o);
        end
      end else if (i >= 7 && i <= 9) begin
        checks++;
        if (edge_o[3] !== 1'b0) begin
          errors++;
          $display("FAIL midrst_prime i%0d: got edge3=%b want 0", i, edge_o[3]);
        end
      end else if (i >= 10 || (i >= 2 && i <= 5)) begin
        checks++;
        if (edge_o[3] !== 1'b1) begin
          errors++;
          $display("FAIL midrst_pulse i%0d: got edge3=%b want 1", i, edge_o[3]);
        end
      end
    end
    rst = 1'b0;
  endtask

`ifdef EDGE_DEBOUNCE_EN
  task automatic test_debounce();
    set_modes(EDGE_OFF, EDGE_OFF, EDGE_OFF, EDGE_BOTH);
    x = 4'b0000;
    tick(8);
    clear_all();
    x[0] = 1'b1; tick(3);
    x[0] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (edge_o[0] !== 1'b0 || level_o[0] !== 1'b0) begin
        errors++;
        $display("FAIL db_glitch i%0d: got edge0=%b level0=%b want 0/0", i, edge_o[0], level_o[0]);
      end
    end
    x[0] = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++;
      if (rise_o[0] !== (i == 7)) begin
        errors++;
        $display("FAIL db_rise cyc%0d: got rise0=%b want %b", i, rise_o[0], (i == 7));
      end
    end
  endtask
`endif

  initial begin
    rst = 1'b1; x = '0; cnt_clr = '0; sticky_clr = '0;
    set_modes(EDGE_BOTH, EDGE_BOTH, EDGE_BOTH, EDGE_BOTH);
    test_reset();
`ifdef EDGE_DEBOUNCE_EN
    test_debounce();
`else
    test_rise_fall();
    test_modes();
    test_saturation();
    test_sticky();
    test_back_to_back();
    test_reset_mid();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
